// File: rtl/riscv_fencei_seq.sv
// FENCE.I sequencer: drains data traffic, writes back D$, invalidates I$, then releases the pipeline.
// Build option RISCV_FENCEI_DCACHE_EN enables the DRAIN/DC_REQ phases; otherwise the sequence is I$-only.
module riscv_fencei_seq #(
  parameter int unsigned ACK_TIMEOUT = 256,
  parameter int unsigned CNT_BITS    = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                bu_cacheflush,
  input  logic                du_stall,
  input  logic                dmem_busy,
  output logic                dc_flush_req,
  input  logic                dc_flush_ack,
  output logic                ic_inv_req,
  input  logic                ic_inv_ack,
  output logic                fl_stall,
  output logic                fl_busy,
  output logic                fl_done,
  output logic                fl_error,
  output logic [CNT_BITS-1:0] fl_count
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DRAIN  = 3'd1;
  localparam logic [2:0] DC_REQ = 3'd2;
  localparam logic [2:0] IC_REQ = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);

`ifdef RISCV_FENCEI_DCACHE_EN
  localparam logic [2:0] FIRST = DRAIN;
`else
  localparam logic [2:0] FIRST = IC_REQ;
`endif

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic          pending;
  logic          pending_nxt;
  logic          err;
  logic          err_nxt;
  logic [TW-1:0] timer;
  logic          expired;

  assign expired  = (timer == T_LAST);
  assign fl_stall = bu_cacheflush | pending | fl_busy;

  // An ack is tested before expiry, so an ack arriving on the last timer cycle is a success.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    err_nxt     = err;
    if (bu_cacheflush) pending_nxt = 1'b1;
    case (state)
      IDLE: begin
        if ((bu_cacheflush | pending) & ~du_stall) begin
          state_nxt   = FIRST;
          pending_nxt = 1'b0;
        end
      end
`ifdef RISCV_FENCEI_DCACHE_EN
      DRAIN: begin
        if (!dmem_busy) begin
          state_nxt = DC_REQ;
        end else if (expired) begin
          state_nxt = DC_REQ;
          err_nxt   = 1'b1;
        end
      end
      DC_REQ: begin
        if (dc_flush_ack) begin
          state_nxt = IC_REQ;
        end else if (expired) begin
          state_nxt = IC_REQ;
          err_nxt   = 1'b1;
        end
      end
`endif
      IC_REQ: begin
        if (ic_inv_ack) begin
          state_nxt = DONE;
        end else if (expired) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end
      end
      DONE: begin
        if (pending & ~du_stall) begin
          state_nxt   = FIRST;
          pending_nxt = bu_cacheflush;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      pending    <= 1'b0;
      err        <= 1'b0;
      timer      <= '0;
      ic_inv_req <= 1'b0;
      fl_busy    <= 1'b0;
      fl_done    <= 1'b0;
      fl_error   <= 1'b0;
      fl_count   <= '0;
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      err        <= (state_nxt == DONE) ? 1'b0 : err_nxt;
      ic_inv_req <= (state_nxt == IC_REQ);
      fl_busy    <= (state_nxt != IDLE);
      fl_done    <= (state_nxt == DONE);
      fl_error   <= (state_nxt == DONE) & err_nxt;
      if (state_nxt != state) begin
        timer <= '0;
      end else if (state == DRAIN || state == DC_REQ || state == IC_REQ) begin
        timer <= timer + TW'(1);
      end
      if (state_nxt == DONE && fl_count != '1) begin
        fl_count <= fl_count + CNT_BITS'(1);
      end
    end
  end

`ifdef RISCV_FENCEI_DCACHE_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) dc_flush_req <= 1'b0;
    else       dc_flush_req <= (state_nxt == DC_REQ);
  end
`else
  logic unused_dc;
  assign dc_flush_req = 1'b0;
  assign unused_dc    = ^{dc_flush_ack, dmem_busy, DRAIN, DC_REQ};
`endif

endmodule
